pixel_packer_bram: RTL and testbench

Packs a stream of 8-bit pixels into 32-bit words and writes them to the image BRAM through port A (wea/addra/dina). It is the write-side counterpart of the port-B word-to-byte unpacker. Lane order is fixed: the first pixel of each group goes to dina[7:0], the fourth to dina[31:24]. The read side therefore recovers pixels in arrival order, with byte lane 0 first. It sits between the pixel source (camera/UART loader/filter output) and the BRAM write port. It reports frame completion and overflow.

---
 rtl/pixel_packer_bram_pkg.sv | 15 +
 rtl/pixel_packer_bram_if.sv | 26 ++
 rtl/pixel_packer_bram.sv | 99 +++++++++
 tb/tb_pixel_packer_bram.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_packer_bram_pkg.sv
// Shared constants and state encoding for the pixel-to-word packer.
// Lane order: first pixel of a group lands in bits [7:0].
package pixel_pack_pkg;

   localparam int PIX_W  = 8;
   localparam int LANES  = 4;
   localparam int WORD_W = PIX_W * LANES;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PACK = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pixel_packer_bram_if.sv
// Pixel stream in, BRAM port-A write out.
// master = pixel source / BRAM side, slave = packer.
interface pixel_packer_bram_if #(
   parameter int ADDR_W = 14
);
   import pixel_pack_pkg::*;

   logic [PIX_W-1:0]  pix_in;
   logic              pix_valid;
   logic              pix_last;
   logic              pix_ready;
   logic              wea;
   logic [ADDR_W-1:0] addra;
   logic [WORD_W-1:0] dina;

   modport master (
      output pix_in, pix_valid, pix_last,
      input  pix_ready, wea, addra, dina
   );

   modport slave (
      input  pix_in, pix_valid, pix_last,
      output pix_ready, wea, addra, dina
   );

endinterface

// File: rtl/pixel_packer_bram.sv
// Packs 8-bit pixels into 32-bit words and writes them to BRAM port A.
// One write per 4 pixels, or a zero-padded partial word on pix_last.
module pixel_packer_bram
   import pixel_pack_pkg::*;
#(
   parameter int ADDR_W    = 14,
   parameter int NUM_WORDS = 16384
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   pixel_packer_bram_if.slave px,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   state_t            state;
   logic [1:0]        lane;
   logic [WORD_W-1:0] sr;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] word;
   logic              flush;

   always_comb begin
      word = sr;
      word[lane*PIX_W +: PIX_W] = px.pix_in;
      flush = (lane == 2'd3) || px.pix_last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         lane       <= '0;
         sr         <= '0;
         addr       <= '0;
         px.wea     <= 1'b0;
         px.addra   <= '0;
         px.dina    <= '0;
         px.pix_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         word_count <= '0;
      end else begin
         px.wea <= 1'b0;
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state        <= ST_PACK;
                  lane         <= '0;
                  sr           <= '0;
                  addr         <= '0;
                  word_count   <= '0;
                  overflow     <= 1'b0;
                  done         <= 1'b0;
                  busy         <= 1'b1;
                  px.pix_ready <= 1'b1;
               end else if (px.pix_valid && state == ST_DONE) begin
                  overflow <= 1'b1;
               end
            end
            ST_PACK: begin
               if (px.pix_valid) begin
                  if (flush) begin
                     px.wea     <= 1'b1;
                     px.dina    <= word;
                     px.addra   <= addr;
                     word_count <= word_count + (ADDR_W+1)'(1);
                     lane       <= '0;
                     sr         <= '0;
                     // the last word of the buffer closes the frame, no wrap
                     if (px.pix_last || addr == LAST_ADDR) begin
                        state        <= ST_DONE;
                        busy         <= 1'b0;
                        px.pix_ready <= 1'b0;
                        done         <= 1'b1;
                     end else begin
                        addr <= addr + ADDR_W'(1);
                     end
                  end else begin
                     sr   <= word;
                     lane <= lane + 2'd1;
                  end
               end
            end
            default: begin
               state        <= ST_IDLE;
               busy         <= 1'b0;
               px.pix_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_packer_bram.sv
// Scoreboard bench: a reference packer model pushes expected writes,
// a negedge monitor pops and compares them against wea beats.
module tb_pixel_packer_bram;

   localparam int AW = 14;
   localparam int NW = 4;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
      int            stamp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done, overflow;
   logic [AW:0] word_count;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   exp_t q[$];

   bit          m_pack, m_done, m_ovf;
   int          m_lane, m_addr, m_cnt;
   logic [31:0] m_word;

   pixel_packer_bram_if #(.ADDR_W(AW)) bus ();

   pixel_packer_bram #(.ADDR_W(AW), .NUM_WORDS(NW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .px         (bus.slave),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .word_count (word_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.wea === 1'b1) begin
         if (q.size() == 0) begin
            chk("extra_wea", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("addra", 64'(bus.addra), 64'(e.a));
            chk("dina", 64'(bus.dina), 64'(e.d));
            chk("wea_lat", 64'(cyc), 64'(e.stamp));
         end
      end
   end

   function automatic void m_reset();
      m_pack = 0; m_done = 0; m_ovf = 0;
      m_lane = 0; m_addr = 0; m_cnt = 0; m_word = '0;
   endfunction

   // one cycle of stimulus; model updated against the upcoming edge
   task automatic drive(input bit v, input logic [7:0] d,
                        input bit last, input bit st);
      bus.pix_valid = v;
      bus.pix_in    = d;
      bus.pix_last  = last;
      start         = st;
      if (st && !m_pack) begin
         m_pack = 1; m_done = 0; m_ovf = 0;
         m_lane = 0; m_addr = 0; m_cnt = 0; m_word = '0;
      end else if (v && m_pack) begin
         m_word[m_lane*8 +: 8] = d;
         if (m_lane == 3 || last) begin
            exp_t e;
            e.a = AW'(m_addr);
            e.d = m_word;
            e.stamp = cyc + 1;
            q.push_back(e);
            m_cnt++;
            m_lane = 0;
            m_word = '0;
            if (last || m_addr == NW - 1) begin
               m_pack = 0;
               m_done = 1;
            end else begin
               m_addr++;
            end
         end else begin
            m_lane++;
         end
      end else if (v && m_done) begin
         m_ovf = 1;
      end
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'b0;
      start         = 1'b0;
   endtask

   task automatic pix(input logic [7:0] d, input bit last);
      drive(1, d, last, 0);
   endtask

   task automatic idle();
      drive(0, 8'h00, 0, 0);
   endtask

   task automatic arm();
      drive(0, 8'h00, 0, 1);
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_done"}, 64'(done), 64'(m_done));
      chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
      chk({tag, "_cnt"}, 64'(word_count), 64'(m_cnt));
      chk({tag, "_busy"}, 64'({busy, bus.pix_ready}), {62'd0, m_pack, m_pack});
      chk({tag, "_drain"}, 64'(q.size()), 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wea"}, 64'(bus.wea), 0);
      chk({tag, "_addra"}, 64'(bus.addra), 0);
      chk({tag, "_dina"}, 64'(bus.dina), 0);
      chk_status(tag);
   endtask

   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'b0;
      bus.pix_in    = '0;
      m_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset("rst");

      // back-to-back, last on a full 4th lane
      arm();
      chk_status("armed");
      for (int i = 1; i <= 8; i++) pix(8'(i), i == 8);
      idle();
      chk_status("b2b");

      // partial final word, zero padded
      arm();
      for (int i = 0; i < 6; i++) pix(8'(8'hA0 + i), i == 5);
      idle();
      chk_status("partial");

      // gapped stream
      arm();
      for (int i = 1; i <= 8; i++) begin
         pix(8'(i), i == 8);
         idle();
      end
      idle();
      chk_status("gapped");

      // capacity: 20 pixels, no last
      arm();
      for (int i = 0; i < 20; i++) begin
         pix(8'(8'h30 + i), 0);
         if (i == 15) chk("cap_done16", 64'(done), 1);
      end
      idle();
      chk_status("cap");
      chk("cap_addra", 64'(bus.addra), 64'(NW - 1));

      // restart from DONE with a coincident pixel that must be dropped
      drive(1, 8'h55, 0, 1);
      chk_status("restart");
      for (int i = 0; i < 4; i++) pix(8'(8'h10 + i), 0);
      idle();
      chk_status("rs_word");

      // reset in the middle of a word
      pix(8'hE0, 0);
      pix(8'hE1, 0);
      rst = 1'b1;
      m_reset();
      idle();
      idle();
      rst = 1'b0;
      chk_reset("midrst");

      // pixel in IDLE is dropped without overflow
      pix(8'h77, 0);
      idle();
      chk_status("idlepix");

      arm();
      for (int i = 0; i < 4; i++) pix(8'(8'hC0 + i), i == 3);
      idle();
      chk_status("fresh");

      chk("final_drain", 64'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
